mem_bus_access: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register outputs (aluop, mem_addr, reg2, wd, wreg, wdata).

---
 rtl/mem_bus_access_if.sv | 18 +
 rtl/mem_bus_access.sv | 219 +++++++++++++++++++++
 tb/tb_mem_bus_access.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_access_if.sv
// Single-beat Wishbone-style data bus between the MEM stage (master) and memory (slave).
interface mem_bus_access_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [SW-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic          ack;

  modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack);
  modport slave  (input cyc, stb, we, sel, adr, wdat, output rdat, ack);
endinterface

// File: rtl/mem_bus_access.sv
// MEM stage: issues loads/stores as single-beat bus cycles, stalls the pipe while
// a cycle is outstanding and presents the write-back triple to MEM/WB.
module mem_bus_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              mem_wd_i,
  input  logic                    mem_wreg_i,
  input  logic [31:0]             mem_wdata_i,
  input  logic [7:0]              mem_aluop_i,
  input  logic [31:0]             mem_mem_addr_i,
  input  logic [31:0]             mem_reg2_i,
  input  logic [5:0]              stall_i,
  output logic                    stallreq_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [31:0]             wdata_o,
  mem_bus_access_if.master        bus,
  output logic                    addr_err_o,
  output logic                    bus_err_o
);
  localparam int unsigned DW        = 32;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned STALL_MEM = 4;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [DW-1:0]   adr_q, adr_d, wdat_q, wdat_d, cap_q, cap_d;
  logic            sign_q, sign_d, ld_ok_q, ld_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            aerr_q, aerr_d, aerr_seen_q, aerr_seen_d, berr_q, berr_d;

  logic            is_load, is_store, is_mem, op_sgn, mis;
  logic [3:0]      sel_dec;
  logic [DW-1:0]   st_data;
  logic            unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:0]};
  assign is_mem       = is_load | is_store;

  // Opcode decode: byte lanes (big-endian), alignment and store replication.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    op_sgn   = 1'b0;
    mis      = 1'b0;
    sel_dec  = 4'b0000;
    st_data  = mem_reg2_i;
    case (mem_aluop_i)
      OP_LB, OP_LBU, OP_SB: sel_dec = 4'b1000 >> mem_mem_addr_i[1:0];
      OP_LH, OP_LHU, OP_SH: begin
        sel_dec = mem_mem_addr_i[1] ? 4'b0011 : 4'b1100;
        mis     = mem_mem_addr_i[0];
      end
      OP_LW, OP_SW: begin
        sel_dec = 4'b1111;
        mis     = |mem_mem_addr_i[1:0];
      end
      default: ;
    endcase
    case (mem_aluop_i)
      OP_LB, OP_LH:          begin is_load = 1'b1; op_sgn = 1'b1; end
      OP_LBU, OP_LHU, OP_LW: is_load = 1'b1;
      OP_SB: begin is_store = 1'b1; st_data = {4{mem_reg2_i[7:0]}}; end
      OP_SH: begin is_store = 1'b1; st_data = {2{mem_reg2_i[15:0]}}; end
      OP_SW: is_store = 1'b1;
      default: ;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  function automatic logic [DW-1:0] extend_load(input logic [3:0] sel, input logic sgn,
                                                input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    case (sel)
      4'b1000: r = {{24{sgn & d[31]}}, d[31:24]};
      4'b0100: r = {{24{sgn & d[23]}}, d[23:16]};
      4'b0010: r = {{24{sgn & d[15]}}, d[15:8]};
      4'b0001: r = {{24{sgn & d[7]}},  d[7:0]};
      4'b1100: r = {{16{sgn & d[31]}}, d[31:16]};
      4'b0011: r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    cap_d       = cap_q;
    sign_d      = sign_q;
    ld_ok_d     = ld_ok_q;
    cnt_d       = cnt_q;
    aerr_d      = 1'b0;
    aerr_seen_d = aerr_seen_q;
    berr_d      = 1'b0;
    stallreq_o  = 1'b0;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    case (state_q)
      S_IDLE: begin
        aerr_seen_d = 1'b0;
        wd_o        = mem_wd_i;
        if (is_mem && mis) begin
          // A held misaligned op must report only once.
          aerr_d      = ~aerr_seen_q;
          aerr_seen_d = stall_i[STALL_MEM];
        end else if (is_mem) begin
          stallreq_o = 1'b1;
          state_d    = S_BUS;
          cyc_d      = 1'b1;
          we_d       = is_store;
          sel_d      = sel_dec;
          adr_d      = {mem_mem_addr_i[31:2], 2'b00};
          wdat_d     = is_store ? st_data : '0;
          sign_d     = op_sgn;
          ld_ok_d    = 1'b0;
          cnt_d      = '0;
        end else begin
          wreg_o  = mem_wreg_i;
          wdata_o = mem_wdata_i;
        end
      end
      S_BUS: begin
        stallreq_o = 1'b1;
        wd_o       = mem_wd_i;
        if (bus.ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cap_d   = extend_load(sel_q, sign_q, bus.rdat);
          ld_ok_d = ~we_q;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b1;
          ld_ok_d = 1'b0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        wd_o    = mem_wd_i;
        wreg_o  = ld_ok_q & mem_wreg_i;
        wdata_o = ld_ok_q ? cap_q : '0;
        if (!stall_i[STALL_MEM]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Write-back and stall request read as zero while reset is asserted.
    if (!rst) begin
      stallreq_o = 1'b0;
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      cap_q       <= '0;
      sign_q      <= 1'b0;
      ld_ok_q     <= 1'b0;
      cnt_q       <= '0;
      aerr_q      <= 1'b0;
      aerr_seen_q <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      cap_q       <= cap_d;
      sign_q      <= sign_d;
      ld_ok_q     <= ld_ok_d;
      cnt_q       <= cnt_d;
      aerr_q      <= aerr_d;
      aerr_seen_q <= aerr_seen_d;
      berr_q      <= berr_d;
    end
  end

  assign bus.cyc    = cyc_q;
  assign bus.stb    = cyc_q;
  assign bus.we     = we_q;
  assign bus.sel    = sel_q;
  assign bus.adr    = adr_q;
  assign bus.wdat   = wdat_q;
  assign addr_err_o = aerr_q;
  assign bus_err_o  = berr_q;
endmodule

// File: tb/tb_mem_bus_access.sv
// Bench for mem_bus_access: directed table, reset corners and random ops vs a lane-level model.
module tb_mem_bus_access;
  localparam int T = 4;
  localparam logic [7:0] OP_LB  = 8'hE0, OP_LH  = 8'hE1, OP_LW  = 8'hE3, OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5, OP_SB  = 8'hE8, OP_SH  = 8'hE9, OP_SW  = 8'hEB;
  localparam logic [7:0] OP_ADD = 8'h20, OP_NOP = 8'h00;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr, reg2, rdat, wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [3:0]  lat, hold;
    logic        mem, mis, we;
    logic [3:0]  sel;
    logic [31:0] dat_o, res;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0, addr_i = '0, reg2_i = '0;
  logic [7:0]  aluop_i = '0;
  logic [5:0]  stall_i = '0;
  logic        stallreq_o, wreg_o, addr_err_o, bus_err_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;
  int checks = 0, failures = 0;
  string tag = "reset";

  mem_bus_access_if bus_if();

  mem_bus_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .mem_wd_i(wd_i), .mem_wreg_i(wreg_i), .mem_wdata_i(wdata_i),
    .mem_aluop_i(aluop_i), .mem_mem_addr_i(addr_i), .mem_reg2_i(reg2_i), .stall_i(stall_i),
    .stallreq_o(stallreq_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .bus(bus_if),
    .addr_err_o(addr_err_o), .bus_err_o(bus_err_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tag, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, reg2, rdat,
                              input int lat, hold, input logic mem, mis, we,
                              input logic [3:0] sel, input logic [31:0] dat_o, res);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.rdat = rdat; v.wdata = 32'h0000_0005;
    v.wd = 5'd3; v.wreg = 1'b1; v.lat = 4'(lat); v.hold = 4'(hold);
    v.mem = mem; v.mis = mis; v.we = we; v.sel = sel; v.dat_o = dat_o; v.res = res;
    return v;
  endfunction

  // Transaction-level reference: lanes, replication and extension from access size and offset.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int size, off;
    logic sgn;
    logic [31:0] x, mask;
    v.mem = 1'b0; v.mis = 1'b0; v.we = 1'b0; v.sel = '0; v.dat_o = '0; v.res = '0;
    sgn = 1'b0; size = 0;
    case (v.op)
      OP_LB:  begin size = 1; sgn = 1'b1; end
      OP_LBU: size = 1;
      OP_LH:  begin size = 2; sgn = 1'b1; end
      OP_LHU: size = 2;
      OP_LW:  size = 4;
      OP_SB:  begin size = 1; v.we = 1'b1; end
      OP_SH:  begin size = 2; v.we = 1'b1; end
      OP_SW:  begin size = 4; v.we = 1'b1; end
      default: size = 0;
    endcase
    off = int'(v.addr[1:0]);
    if (size != 0) begin
      v.mem = 1'b1;
      v.mis = (off % size) != 0;
      for (int i = 0; i < size; i++) if (off + i < 4) v.sel[3 - (off + i)] = 1'b1;
      for (int i = 0; i < 4; i++) v.dat_o[8*i +: 8] = v.reg2[8*(i % size) +: 8];
      if (!v.mis) begin
        x = v.rdat >> (8 * (4 - off - size));
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          x = x & mask;
          if (sgn && x[8*size-1]) x = x | ~mask;
        end
        v.res = x;
      end
    end
    return v;
  endfunction

  // Drive one instruction through detect, bus and hold phases, checking every cycle.
  task automatic run(input vec_t v);
    int lat = int'(v.lat), hold = int'(v.hold), nb;
    logic to;
    tick();
    aluop_i = v.op; addr_i = v.addr; reg2_i = v.reg2; wdata_i = v.wdata;
    wd_i = v.wd; wreg_i = v.wreg; bus_if.rdat = v.rdat;
    bus_if.ack = 1'($urandom_range(0, 1));
    stall_i = (v.mis && hold != 0) ? 6'b010000 : 6'b0;
    @(negedge clk);
    chk("det_stallreq", 32'(stallreq_o), 32'(v.mem && !v.mis));
    chk("det_cyc", 32'(bus_if.cyc), 32'd0);
    chk("det_wreg", 32'(wreg_o), v.mem ? 32'd0 : 32'(v.wreg));
    chk("det_errs", 32'({addr_err_o, bus_err_o}), 32'd0);
    if (!v.mem) begin
      chk("pass_wd", 32'(wd_o), 32'(v.wd));
      chk("pass_wdata", wdata_o, v.wdata);
    end else if (v.mis) begin
      for (int c = 1; c <= hold + 1; c++) begin
        tick();
        bus_if.ack = 1'($urandom_range(0, 1));
        if (c <= hold) stall_i = (c < hold) ? 6'b010000 : 6'b0;
        else begin aluop_i = OP_NOP; stall_i = 6'b0; end
        @(negedge clk);
        chk("mis_addr_err", 32'(addr_err_o), 32'(c == 1));
        chk("mis_cyc", 32'(bus_if.cyc), 32'd0);
        chk("mis_stallreq", 32'(stallreq_o), 32'd0);
        if (c <= hold) chk("mis_wreg", 32'(wreg_o), 32'd0);
      end
    end else begin
      to = (lat >= T);
      nb = to ? T : lat + 1;
      for (int k = 0; k < nb; k++) begin
        tick();
        stall_i = 6'b011111;
        bus_if.ack = (k == lat);
        @(negedge clk);
        chk("bus_cyc_stb", 32'({bus_if.cyc, bus_if.stb}), 32'd3);
        chk("bus_we", 32'(bus_if.we), 32'(v.we));
        chk("bus_sel", 32'(bus_if.sel), 32'(v.sel));
        chk("bus_adr", bus_if.adr, v.addr & ~32'h3);
        if (v.we) chk("bus_dat_o", bus_if.wdat, v.dat_o);
        chk("bus_stallreq", 32'(stallreq_o), 32'd1);
        chk("bus_wreg", 32'(wreg_o), 32'd0);
        chk("bus_err_early", 32'(bus_err_o), 32'd0);
      end
      for (int h = 0; h <= hold; h++) begin
        tick();
        bus_if.ack = 1'($urandom_range(0, 1));
        stall_i = (h < hold) ? 6'b010000 : 6'b0;
        @(negedge clk);
        chk("hold_cyc", 32'(bus_if.cyc), 32'd0);
        chk("hold_stallreq", 32'(stallreq_o), 32'd0);
        chk("hold_bus_err", 32'(bus_err_o), 32'(to && h == 0));
        chk("hold_wreg", 32'(wreg_o), 32'(!to && !v.we && v.wreg));
        if (!to && !v.we && v.wreg) begin
          chk("hold_wdata", wdata_o, v.res);
          chk("hold_wd", 32'(wd_o), 32'(v.wd));
        end
      end
    end
  endtask

  vec_t tbl[14];

  initial begin
    vec_t v;
    bus_if.ack = 1'b0; bus_if.rdat = '0;
    tbl[0]  = mk(OP_ADD, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0);
    tbl[1]  = mk(OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    tbl[2]  = mk(OP_LB,  32'h101, 32'h0,        32'h12F45678, 0, 1, 1, 0, 0, 4'b0100, 32'h0,        32'hFFFFFFF4);
    tbl[3]  = mk(OP_LBU, 32'h101, 32'h0,        32'h12F45678, 0, 0, 1, 0, 0, 4'b0100, 32'h0,        32'h000000F4);
    tbl[4]  = mk(OP_SH,  32'h102, 32'h0000ABCD, 32'h0,        0, 1, 1, 0, 1, 4'b0011, 32'hABCDABCD, 32'h0);
    tbl[5]  = mk(OP_LW,  32'h102, 32'h0,        32'h0,        0, 2, 1, 1, 0, 4'b1111, 32'h0,        32'h0);
    tbl[6]  = mk(OP_LH,  32'h102, 32'h0,        32'h12348765, 2, 1, 1, 0, 0, 4'b0011, 32'h0,        32'hFFFF8765);
    tbl[7]  = mk(OP_LHU, 32'h100, 32'h0,        32'h87651234, 0, 0, 1, 0, 0, 4'b1100, 32'h0,        32'h00008765);
    tbl[8]  = mk(OP_LB,  32'h103, 32'h0,        32'hAABBCC7F, 0, 0, 1, 0, 0, 4'b0001, 32'h0,        32'h0000007F);
    tbl[9]  = mk(OP_SB,  32'h101, 32'h1234565A, 32'h0,        0, 0, 1, 0, 1, 4'b0100, 32'h5A5A5A5A, 32'h0);
    tbl[10] = mk(OP_SW,  32'h204, 32'hCAFEF00D, 32'h0,        3, 0, 1, 0, 1, 4'b1111, 32'hCAFEF00D, 32'h0);
    tbl[11] = mk(OP_LW,  32'h300, 32'h0,        32'h0,        5, 2, 1, 0, 0, 4'b1111, 32'h0,        32'h0);
    tbl[12] = mk(OP_LH,  32'h105, 32'h0,        32'h0,        0, 0, 1, 1, 0, 4'b1100, 32'h0,        32'h0);
    tbl[13] = mk(OP_LW,  32'h308, 32'h0,        32'h01234567, 3, 0, 1, 0, 0, 4'b1111, 32'h0,        32'h01234567);

    // Reset with live inputs: everything reads zero.
    aluop_i = OP_ADD; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h55;
    #1;
    chk("rst_wb", {26'(wd_o), wreg_o, 5'(0)} | wdata_o, 32'd0);
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_bus", 32'({bus_if.cyc, bus_if.stb, bus_if.we, bus_if.sel}), 32'd0);
    chk("rst_adr_dat", bus_if.adr | bus_if.wdat, 32'd0);
    chk("rst_errs", 32'({addr_err_o, bus_err_o}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("tbl%0d", i);
      run(tbl[i]);
    end

    // Reset in the middle of a bus cycle drops it immediately.
    tag = "rst_mid_bus";
    tick();
    aluop_i = OP_LW; addr_i = 32'h400; stall_i = 6'b0; bus_if.ack = 1'b0;
    tick();
    @(negedge clk);
    chk("cyc_before", 32'(bus_if.cyc), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("cyc_dropped", 32'(bus_if.cyc), 32'd0);
    chk("stallreq_dropped", 32'(stallreq_o), 32'd0);
    aluop_i = OP_ADD; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h77;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {wdata_o[23:0], 3'(0), wd_o}, {24'h77, 3'(0), 5'd9});
    chk("no_cyc_after_rst", 32'({bus_if.cyc, stallreq_o}), 32'd0);

    for (int n = 0; n < 400; n++) begin
      tag = $sformatf("rnd%0d", n);
      case ($urandom_range(0, 11))
        0: v.op = OP_LB;  1: v.op = OP_LBU; 2: v.op = OP_LH;  3: v.op = OP_LHU;
        4: v.op = OP_LW;  5: v.op = OP_SB;  6: v.op = OP_SH;  7: v.op = OP_SW;
        8: v.op = OP_NOP; 9: v.op = OP_ADD; default: v.op = 8'($urandom);
      endcase
      v.addr = $urandom; v.reg2 = $urandom; v.rdat = $urandom; v.wdata = $urandom;
      v.wd = 5'($urandom); v.wreg = 1'($urandom);
      v.lat = 4'($urandom_range(0, 5)); v.hold = 4'($urandom_range(0, 2));
      run(model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
